// File: rtl/tone_divider_bank.sv
// Multi-channel runtime-programmable square-wave divider for the tone path.
// Each channel toggles clk_out every N enabled clk_in edges (N = half-period).
// New divider values arrive over a valid/ready port, wait in a one-deep
// per-channel pending slot, and take effect only at a half-period boundary
// (or immediately when the channel is disabled or silent).
//
// Ports:
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   cfg_valid   config request valid
//   cfg_ready   config request can be accepted (combinational)
//   cfg_ch      target channel index (out-of-range indices are accepted and dropped)
//   cfg_div     new half-period N, 0 = silent
//   ch_en       per-channel enable level
//   clk_out     per-channel square wave
//   rise_pulse  per-channel strobe, high in the cycle clk_out[i] becomes 1
module tone_divider_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 16744,
  parameter int unsigned CH_W        = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] rise_pulse
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    div_active_q  [CHANNELS];
  logic [CNT_W-1:0]    div_active_d  [CHANNELS];
  logic [CNT_W-1:0]    div_pending_q [CHANNELS];
  logic [CNT_W-1:0]    div_pending_d [CHANNELS];
  logic [CNT_W-1:0]    count_q       [CHANNELS];
  logic [CNT_W-1:0]    count_d       [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;
  logic [CHANNELS-1:0] clk_out_d;
  logic [CHANNELS-1:0] rise_pulse_d;
  logic [CHANNELS-1:0] cfg_accept;

  // Ready reflects the addressed channel's pending slot; unknown channels always accept.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_q[i];
    end
  end

  // Per-channel handshake decode; nothing matches for out-of-range indices.
  always_comb begin
    cfg_accept = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cfg_accept[i] = cfg_valid & (cfg_ch == CH_W'(i)) & ~pend_q[i];
    end
  end

  // Next-state for every channel.
  always_comb begin
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    count_d       = count_q;
    pend_d        = pend_q;
    clk_out_d     = clk_out;
    rise_pulse_d  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (!ch_en[i] || (div_active_q[i] == '0)) begin
        // Idle or silent: hold low, restart count, take any pending value now.
        count_d[i]   = '0;
        clk_out_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_active_d[i] = div_pending_q[i];
          pend_d[i]       = 1'b0;
        end
      end else if (count_q[i] == div_active_q[i] - CNT_W'(1)) begin
        // Half-period boundary: the only glitch-free point to swap dividers.
        count_d[i] = '0;
        if (pend_q[i]) begin
          div_active_d[i] = div_pending_q[i];
          pend_d[i]       = 1'b0;
          clk_out_d[i]    = (div_pending_q[i] == '0) ? 1'b0 : ~clk_out[i];
        end else begin
          clk_out_d[i] = ~clk_out[i];
        end
      end else begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end
      // Accept and apply are exclusive: accept needs an empty slot, apply a full one.
      if (cfg_accept[i]) begin
        div_pending_d[i] = cfg_div;
        pend_d[i]        = 1'b1;
      end
      rise_pulse_d[i] = ~clk_out[i] & clk_out_d[i];
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        div_active_q[i]  <= RESET_DIV;
        div_pending_q[i] <= '0;
        count_q[i]       <= '0;
      end
      pend_q     <= '0;
      clk_out    <= '0;
      rise_pulse <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        div_active_q[i]  <= div_active_d[i];
        div_pending_q[i] <= div_pending_d[i];
        count_q[i]       <= count_d[i];
      end
      pend_q     <= pend_d;
      clk_out    <= clk_out_d;
      rise_pulse <= rise_pulse_d;
    end
  end

endmodule

// File: tb/tb_tone_divider_bank.sv
// Self-checking bench for tone_divider_bank: table-driven start-up vectors,
// hand sequences for config/boundary corners, randomized traffic against a
// countdown-based reference model, and a narrow instance for the maximum divider.
module tb_tone_divider_bank;

  localparam int unsigned CH   = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned DDIV = 3;
  localparam int unsigned CHW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic [CH-1:0]   ch_en;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   rise_pulse;

  logic       big_valid;
  logic       big_ready;
  logic [0:0] big_ch;
  logic [7:0] big_div;
  logic [0:0] big_en;
  logic [0:0] big_clk;
  logic [0:0] big_rise;

  tone_divider_bank #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .CH_W(CHW)) dut (
    .clk_in(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ch_en(ch_en), .clk_out(clk_out),
    .rise_pulse(rise_pulse));

  tone_divider_bank #(.CHANNELS(1), .CNT_W(8), .DEFAULT_DIV(255), .CH_W(1)) dut_big (
    .clk_in(clk), .rst_n(rst_n), .cfg_valid(big_valid), .cfg_ready(big_ready),
    .cfg_ch(big_ch), .cfg_div(big_div), .ch_en(big_en), .clk_out(big_clk),
    .rise_pulse(big_rise));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each channel counts down the edges left in the current half-period.
  int m_active [CH];
  int m_rem    [CH];
  bit m_level  [CH];
  bit m_rise   [CH];
  bit m_pend   [CH];
  int m_pval   [CH];

  function automatic void model_reset();
    for (int i = 0; i < int'(CH); i++) begin
      m_active[i] = DDIV; m_rem[i] = DDIV; m_level[i] = 0;
      m_rise[i] = 0; m_pend[i] = 0; m_pval[i] = 0;
    end
  endfunction

  function automatic bit model_ready(input int ch);
    if (ch >= int'(CH)) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic void model_edge(input logic [CH-1:0] en, input bit acc, input int ch, input int div);
    for (int i = 0; i < int'(CH); i++) begin
      bit old;
      old = m_level[i];
      if (!en[i] || m_active[i] == 0) begin
        if (m_pend[i]) begin m_active[i] = m_pval[i]; m_pend[i] = 0; end
        m_level[i] = 0;
        m_rem[i]   = m_active[i];
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          if (m_pend[i]) begin m_active[i] = m_pval[i]; m_pend[i] = 0; end
          m_level[i] = (m_active[i] == 0) ? 1'b0 : !m_level[i];
          m_rem[i]   = m_active[i];
        end
      end
      m_rise[i] = !old && m_level[i];
    end
    if (acc && ch < int'(CH)) begin
      m_pend[ch] = 1;
      m_pval[ch] = div;
    end
  endfunction

  bit last_acc;

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic step(input string tag);
    logic [CH-1:0] en, ec, er;
    int ch, dv;
    bit rdy;
    #1;
    rdy = model_ready(int'(cfg_ch));
    check({tag, " cfg_ready"}, 32'(cfg_ready), 32'(rdy));
    last_acc = cfg_valid && rdy;
    en = ch_en; ch = int'(cfg_ch); dv = int'(cfg_div);
    @(posedge clk);
    #1;
    model_edge(en, last_acc, ch, dv);
    for (int i = 0; i < int'(CH); i++) begin ec[i] = m_level[i]; er[i] = m_rise[i]; end
    check({tag, " clk_out"}, 32'(clk_out), 32'(ec));
    check({tag, " rise_pulse"}, 32'(rise_pulse), 32'(er));
  endtask

  task automatic cfg_send(input string tag, input int ch, input int div, input int bound, output int steps);
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(div);
    steps = -1;
    for (int k = 1; k <= bound; k++) begin
      step(tag);
      if (last_acc) begin steps = k; break; end
    end
    if (steps < 0) check({tag, " accept timeout"}, 32'd0, 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic measure(input string tag, input int ch, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      step(tag);
      if (rise_pulse[ch]) begin n = k; return; end
    end
  endtask

  task automatic big_measure(output int n);
    n = -1;
    for (int k = 1; k <= 600; k++) begin
      step("big");
      if (big_rise[0]) begin n = k; return; end
    end
  endtask

  typedef struct {
    logic [CH-1:0] en;
    logic [CH-1:0] exp_clk;
    logic [CH-1:0] exp_rise;
  } vec_t;

  vec_t tv [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s;
    tv[0] = '{4'b0001, 4'b0000, 4'b0000};
    tv[1] = '{4'b0001, 4'b0000, 4'b0000};
    tv[2] = '{4'b0001, 4'b0001, 4'b0001};
    tv[3] = '{4'b0001, 4'b0001, 4'b0000};
    tv[4] = '{4'b0001, 4'b0001, 4'b0000};
    tv[5] = '{4'b0001, 4'b0000, 4'b0000};
    tv[6] = '{4'b0001, 4'b0000, 4'b0000};
    tv[7] = '{4'b0001, 4'b0000, 4'b0000};
    tv[8] = '{4'b0001, 4'b0001, 4'b0001};
    tv[9] = '{4'b0000, 4'b0000, 4'b0000};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0;
    big_valid = 1'b0; big_ch = '0; big_div = '0; big_en = '0;
    model_reset();
    #12;
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset rise_pulse", 32'(rise_pulse), 32'd0);
    check("reset cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    step("idle"); step("idle");

    // Start-up waveform with the default divider of 3.
    for (int v = 0; v < 10; v++) begin
      ch_en = tv[v].en;
      step("t1");
      check($sformatf("t1 vec%0d clk_out", v), 32'(clk_out), 32'(tv[v].exp_clk));
      check($sformatf("t1 vec%0d rise", v), 32'(rise_pulse), 32'(tv[v].exp_rise));
    end

    // Reload mid half-period: current half finishes at 3, then half-period 5.
    ch_en = 4'b0001;
    step("t2");
    cfg_send("t2 send", 0, 5, 4, s);
    check("t2 accept latency", 32'(s), 32'd1);
    #1 check("t2 ready low while pending", 32'(cfg_ready), 32'd0);
    measure("t2", 0, 40, n);
    check("t2 first rise at old boundary", 32'(n), 32'd1);
    measure("t2", 0, 40, n);
    check("t2 new period", 32'(n), 32'd10);

    // Second request to a pending channel is held; another channel still accepts.
    cfg_send("t3 a", 0, 2, 4, s);
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd4;
    #1 check("t3 hold ready", 32'(cfg_ready), 32'd0);
    step("t3 hold");
    check("t3 hold no accept", 32'(last_acc), 32'd0);
    cfg_ch = 3'd1; cfg_div = 16'd7;
    #1 check("t3 ch1 ready", 32'(cfg_ready), 32'd1);
    step("t3 ch1");
    check("t3 ch1 accepted", 32'(last_acc), 32'd1);
    cfg_send("t3 b", 0, 4, 40, s);

    // Silence a running channel, then restart it with N=2.
    cfg_send("t4 zero", 0, 0, 40, s);
    for (int k = 0; k < 30; k++) step("t4 wait");
    check("t4 silent", 32'(clk_out[0]), 32'd0);
    cfg_send("t4 two", 0, 2, 5, s);
    check("t4 accept latency", 32'(s), 32'd1);
    measure("t4", 0, 20, n);
    check("t4 first rise after restart", 32'(n), 32'd3);
    measure("t4", 0, 20, n);
    check("t4 period", 32'(n), 32'd4);

    // N=1 gives clk_in/2; out-of-range channel is swallowed.
    cfg_send("t5 n1", 2, 1, 5, s);
    ch_en = 4'b0101;
    measure("t5", 2, 20, n);
    measure("t5", 2, 20, n);
    check("t5 n1 period", 32'(n), 32'd2);
    cfg_send("t5 oob", 5, 99, 3, s);
    check("t5 oob accept", 32'(s), 32'd1);
    cfg_ch = 3'd2;
    #1 check("t5 ch2 not pending", 32'(cfg_ready), 32'd1);

    // Maximum divider on the 8-bit instance: half-period 255, period 510.
    big_en = 1'b1;
    big_measure(n);
    check("big first rise", 32'(n), 32'd255);
    big_valid = 1'b1; big_ch = 1'b0; big_div = 8'd255;
    #1 check("big ready", 32'(big_ready), 32'd1);
    step("big cfg");
    big_valid = 1'b0;
    big_measure(n);
    check("big period", 32'(n + 1), 32'd510);

    // Asynchronous reset mid-period with a pending load.
    ch_en = 4'b0101;
    cfg_send("t6 send", 0, 6, 20, s);
    cfg_ch = 3'd0;
    #3 rst_n = 1'b0;
    #1;
    check("t6 async clk_out", 32'(clk_out), 32'd0);
    check("t6 async rise", 32'(rise_pulse), 32'd0);
    check("t6 pending dropped", 32'(cfg_ready), 32'd1);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    measure("t6", 0, 20, n);
    check("t6 default first rise", 32'(n), 32'd3);
    measure("t6", 0, 20, n);
    check("t6 default period", 32'(n), 32'd6);

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 19) == 0) ch_en = CH'($urandom);
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = CHW'($urandom_range(0, 7));
        cfg_div   = CW'($urandom_range(0, 6));
      end
      step("rand");
      if (last_acc) cfg_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_divider_bank.md
Name: tone_divider_bank

Overview:
- Multi-channel, runtime-programmable clock divider for the piano tone path.
- Each channel produces a 50%-duty square wave whose half-period, in clk_in cycles, is loaded at run time through a valid/ready config port.
- Divider updates take effect only at a half-period boundary, so outputs never glitch.
- Replaces fixed-divider instances when several notes must sound at once and change pitch on the fly.

Parameters:
- CHANNELS, 4, number of independent tone channels (1..16).
- CNT_W, 16, width of divider value and counters.
- DEFAULT_DIV, 16744, half-period loaded into every channel at reset; must fit in CNT_W.
- CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= CHANNELS.

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request can be accepted.
- cfg_ch  in  CH_W  target channel index.
- cfg_div  in  CNT_W  new half-period N; 0 means silent.
- ch_en  in  CHANNELS  per-channel enable (level).
- clk_out  out  CHANNELS  per-channel square wave.
- rise_pulse  out  CHANNELS  one-cycle strobe, high in the cycle clk_out[i] becomes 1.

Behaviour:
- Per-channel state: div_active[CNT_W], div_pending[CNT_W], pend_flag, count[CNT_W], clk_out bit, rise_pulse bit. All outputs are registered except cfg_ready.
- Reset (rst_n=0, asynchronous):
  - div_active = DEFAULT_DIV; count = 0; clk_out = 0; rise_pulse = 0; pend_flag = 0.
- cfg_ready (combinational):
  - = !pend_flag[cfg_ch] when cfg_ch < CHANNELS.
  - = 1 when cfg_ch >= CHANNELS; such requests are accepted and discarded.
- Transfer occurs when cfg_valid & cfg_ready at a rising edge: div_pending[cfg_ch] <= cfg_div; pend_flag <= 1.
- At most one pending value per channel. While pending, cfg_ready for that channel is 0, and cfg_valid must stay asserted with stable cfg_ch/cfg_div until accepted.
- Per channel, each rising edge, in priority order:
  1. ch_en=0:
     - count <= 0; clk_out <= 0.
     - If pend_flag: div_active <= div_pending; pend_flag <= 0 (applied immediately).
  2. ch_en=1 and div_active=0 (silent):
     - clk_out <= 0; count <= 0.
     - Pending value applied immediately as in case 1.
  3. ch_en=1, div_active=N>0, count=N-1 (boundary):
     - count <= 0; clk_out toggles.
     - If pend_flag: div_active <= div_pending; pend_flag <= 0.
     - If that new value is 0, clk_out <= 0 instead of toggling.
  4. Otherwise: count <= count+1.
- rise_pulse[i] = 1 exactly in the cycle after an edge where clk_out[i] went 0->1; 0 otherwise.
- Timing:
  - From ch_en rising with count=0, the first clk_out high appears after N enabled edges.
  - Period is 2N cycles, high time N, low time N.
  - N=1 gives clk_in/2.
- A config accepted in the same cycle as a boundary is not applied at that boundary. It is applied at the next boundary.
- Channels are fully independent; a config for one channel never disturbs another.
- cfg_div is compared/stored at CNT_W bits with no arithmetic overflow; the maximum N is 2**CNT_W-1.
- Reset mid-period returns all state to reset values immediately, including dropping any pending config.

Test Plan:
1. Reset release, DEFAULT_DIV overridden to 3 (CHANNELS=4), ch_en=0001 -> clk_out[0] rises on the 3rd edge after enable, period 6, rise_pulse[0] one cycle per period; channels 1-3 stay 0.
2. Ch0 running N=3, load cfg_div=5 mid-half-period -> current half-period completes at 3; subsequent half-periods are 5 cycles; cfg_ready low from acceptance to the boundary.
3. Second cfg_valid to ch0 while pending -> cfg_ready=0 and the request is held; a simultaneous request to ch1 (cfg_ch=1) is accepted the same cycle.
4. Load cfg_div=0 to a running channel -> clk_out goes 0 at the next boundary and stays 0; a later load of N=2 applies next cycle, then toggles every 2 cycles.
5. N=1 and N=65535 (CNT_W=16) -> periods of 2 and 131070 cycles; cfg_ch=5 with CHANNELS=4 -> accepted, no channel changes.
6. Assert rst_n=0 mid-period with a pending load -> all clk_out/rise_pulse 0 asynchronously, pending dropped, div_active = DEFAULT_DIV after release.
